control_sequencer: RTL and testbench

//  Hardwired control unit that steps the bus datapath through fetch, decode and execute of one instruction at a time.

---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/opcode_decoder.sv | 30 +++
 rtl/control_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// sequencer states and the decoded instruction class.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4
  } alu_op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT,
    S_FAULT
  } state_t;

  // One-hot instruction class; all-zero means the opcode is illegal.
  typedef struct packed {
    logic ld;
    logic st;
    logic rtype;
    logic addi;
    logic br;
    logic nop;
    logic halt;
  } iclass_t;

  function automatic alu_op_t rtype_alu(input logic [4:0] opc);
    alu_op_t op;
    case (opc)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: IR opcode field -> one-hot class + illegal flag.
module opcode_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output iclass_t        cls,
  output logic           illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LD:   cls.ld    = 1'b1;
      OP_ST:   cls.st    = 1'b1;
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR:   cls.rtype = 1'b1;
      OP_ADDI: cls.addi  = 1'b1;
      OP_BR:   cls.br    = 1'b1;
      OP_NOP:  cls.nop   = 1'b1;
      OP_HALT: cls.halt  = 1'b1;
      default: illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps the bus datapath through fetch/decode/execute,
// stalling on the memory ready handshake with a bounded wait.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 5,
  parameter int unsigned ALUOPW  = 4,
  parameter int unsigned MEM_TMO = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [31:0]       ir,
  input  logic              con_ff,
  input  logic              mem_ready,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPC,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Cout,
  output logic              BAout,
  output logic              CONin,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic              Read,
  output logic              Write,
  output logic [ALUOPW-1:0] alu_op,
  output logic              run,
  output logic              fault
);

  localparam int unsigned   CNTW     = $clog2(MEM_TMO);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MEM_TMO - 1);

  state_t          state;
  state_t          state_next;
  state_t          done_next;
  logic [CNTW-1:0] wait_cnt;
  iclass_t         cls;
  logic            illegal;
  logic            in_wait;
  logic            timed_out;
  alu_op_t         r_alu;
  logic            unused_ir_bits;

  opcode_decoder #(
    .OPW(OPW)
  ) u_dec (
    .opcode  (ir[31 -: OPW]),
    .cls     (cls),
    .illegal (illegal)
  );

  assign r_alu          = rtype_alu(ir[31 -: OPW]);
  assign unused_ir_bits = ^ir[31-OPW:0];

  assign in_wait   = (state == S_T1)
                   | ((state == S_T6) & cls.ld)
                   | ((state == S_T7) & cls.st);
  assign timed_out = (wait_cnt == CNT_LAST) & ~mem_ready;
  // start is only sampled at instruction boundaries; dropping it mid-instruction lets it finish.
  assign done_next = start ? S_T0 : S_IDLE;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (in_wait && !mem_ready) begin
      wait_cnt <= wait_cnt + CNTW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1: begin
        if (mem_ready)      state_next = S_T2;
        else if (timed_out) state_next = S_FAULT;
      end
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (illegal)       state_next = S_FAULT;
        else if (cls.halt) state_next = S_HALT;
        else if (cls.nop)  state_next = done_next;
        else               state_next = S_T4;
      end
      S_T4:    state_next = S_T5;
      S_T5: begin
        if (cls.rtype || cls.addi) state_next = done_next;
        else                       state_next = S_T6;
      end
      S_T6: begin
        if (cls.br)                          state_next = done_next;
        else if (cls.st)                     state_next = S_T7;
        else if (mem_ready)                  state_next = S_T7;
        else if (timed_out)                  state_next = S_FAULT;
      end
      S_T7: begin
        if (cls.ld)         state_next = done_next;
        else if (mem_ready) state_next = done_next;
        else if (timed_out) state_next = S_FAULT;
      end
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Cout = 1'b0; BAout = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu_op = '0;
    run    = (state != S_IDLE) && (state != S_HALT) && (state != S_FAULT);
    fault  = (state == S_FAULT);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (cls.rtype || cls.addi) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (cls.ld || cls.st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (cls.br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end
      end
      S_T4: begin
        if (cls.rtype) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
          alu_op = ALUOPW'(r_alu);
        end else if (cls.addi || cls.ld || cls.st) begin
          Cout = 1'b1; Zin = 1'b1;
          alu_op = ALUOPW'(ALU_ADD);
        end else if (cls.br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (cls.rtype || cls.addi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls.ld || cls.st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (cls.br) begin
          Cout = 1'b1; Zin = 1'b1;
          alu_op = ALUOPW'(ALU_ADD);
        end
      end
      S_T6: begin
        if (cls.ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (cls.st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (cls.br && con_ff) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        if (cls.ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls.st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: cycle-by-cycle strobe vectors per instruction.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_ready;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic Cout, BAout, CONin, Gra, Grb, Grc, Rin, Rout, Read, Write;
  logic [3:0]  alu_op;
  logic        run;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int excl_bad = 0;

  always #5 clock = ~clock;

  control_sequencer #(.OPW(5), .ALUOPW(4), .MEM_TMO(16)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .con_ff(con_ff),
    .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .BAout(BAout), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run), .fault(fault)
  );

  // {20 strobes, alu_op, run, fault}
  logic [25:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                Cout, BAout, CONin, Gra, Grb, Grc, Rin, Rout, Read, Write,
                alu_op, run, fault};

  localparam logic [19:0] PCOUT = 20'h80000, PCIN = 20'h40000, INCPC = 20'h20000;
  localparam logic [19:0] MARIN = 20'h10000, MDRIN = 20'h08000, MDROUT = 20'h04000;
  localparam logic [19:0] IRIN = 20'h02000, YIN = 20'h01000, ZIN = 20'h00800;
  localparam logic [19:0] ZLOWOUT = 20'h00400, COUT = 20'h00200, BAOUT = 20'h00100;
  localparam logic [19:0] CONIN = 20'h00080, GRA = 20'h00040, GRB = 20'h00020;
  localparam logic [19:0] GRC = 20'h00010, RIN = 20'h00008, ROUT = 20'h00004;
  localparam logic [19:0] READ = 20'h00002, WRITE = 20'h00001;

  localparam logic [25:0] IDLE_V  = 26'd0;
  localparam logic [25:0] FAULT_V = 26'd1;
  localparam logic [25:0] F0 = {PCOUT | MARIN | INCPC | ZIN, 4'd0, 2'b10};
  localparam logic [25:0] F1 = {ZLOWOUT | PCIN | READ | MDRIN, 4'd0, 2'b10};
  localparam logic [25:0] F2 = {MDROUT | IRIN, 4'd0, 2'b10};
  localparam logic [25:0] L3 = {GRB | BAOUT | YIN, 4'd0, 2'b10};
  localparam logic [25:0] L4 = {COUT | ZIN, 4'd1, 2'b10};
  localparam logic [25:0] L5 = {ZLOWOUT | MARIN, 4'd0, 2'b10};
  localparam logic [25:0] R3 = {GRB | ROUT | YIN, 4'd0, 2'b10};
  localparam logic [25:0] R5 = {ZLOWOUT | GRA | RIN, 4'd0, 2'b10};
  localparam logic [25:0] NOSTROBE = {20'd0, 4'd0, 2'b10};

  function automatic logic [25:0] act(input logic [19:0] s, input logic [3:0] a);
    return {s, a, 2'b10};
  endfunction

  // Bus exclusivity and Read/Write exclusion, sampled away from the clock edge.
  always @(negedge clock) begin
    assert ($countones({PCout, MDRout, Zlowout, Cout, BAout, Rout}) <= 1 && !(Read && Write))
    else excl_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic test_reset();
    @(posedge clock); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL reset_hold got %h want %h", obs, IDLE_V);
    end
    clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL reset_idle got %h want %h", obs, IDLE_V);
    end
  endtask

  task automatic test_rtype(input logic [31:0] instr, input logic [3:0] op, input string nm);
    logic [25:0] e[$];
    bit m[$];
    e = '{F0, F1, F2, R3, act(GRC | ROUT | ZIN, op), R5, IDLE_V};
    m = '{1, 1, 1, 1, 1, 1, 1};
    ir = instr; start = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL %s step %0d got %h want %h", nm, i, obs, e[i]);
      end
      mem_ready = m[i];
      if (i == 5) start = 1'b0;
    end
  endtask

  task automatic test_addi();
    logic [25:0] e[$];
    e = '{F0, F1, F2, R3, L4, R5, IDLE_V};
    ir = 32'h6012_0007; start = 1'b1; mem_ready = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL addi step %0d got %h want %h", i, obs, e[i]);
      end
      if (i == 5) start = 1'b0;
    end
  endtask

  task automatic test_ld_wait();
    logic [25:0] e[$];
    bit m[$];
    e = '{F0, F1, F1, F1, F1, F2, L3, L4, L5,
          act(READ | MDRIN, 0), act(READ | MDRIN, 0), act(READ | MDRIN, 0), act(READ | MDRIN, 0),
          act(MDROUT | GRA | RIN, 0), IDLE_V};
    m = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    ir = 32'h0088_0010; start = 1'b1; mem_ready = 1'b0;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL ld_wait step %0d got %h want %h", i, obs, e[i]);
      end
      mem_ready = m[i];
      if (i == 6) start = 1'b0;
    end
  endtask

  task automatic test_st();
    logic [25:0] e[$];
    bit m[$];
    e = '{F0, F1, F2, L3, L4, L5, act(GRA | ROUT | MDRIN, 0),
          act(WRITE, 0), act(WRITE, 0), IDLE_V};
    m = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    ir = 32'h1044_0020; start = 1'b1; mem_ready = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL st step %0d got %h want %h", i, obs, e[i]);
      end
      mem_ready = m[i];
      if (i == 8) start = 1'b0;
    end
  endtask

  task automatic test_br(input logic c);
    logic [25:0] e[$];
    logic [25:0] t6;
    t6 = c ? act(ZLOWOUT | PCIN, 0) : NOSTROBE;
    e = '{F0, F1, F2, act(GRA | ROUT | CONIN, 0), act(PCOUT | YIN, 0),
          act(COUT | ZIN, 1), t6, IDLE_V};
    ir = 32'h9880_0040; con_ff = c; start = 1'b1; mem_ready = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL br_con%0d step %0d got %h want %h", c, i, obs, e[i]);
      end
      if (i == 6) start = 1'b0;
    end
    con_ff = 1'b0;
  endtask

  task automatic test_nop();
    logic [25:0] e[$];
    e = '{F0, F1, F2, NOSTROBE, IDLE_V};
    ir = 32'hD000_0000; start = 1'b1; mem_ready = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL nop step %0d got %h want %h", i, obs, e[i]);
      end
      if (i == 3) start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] e[$];
    e = '{F0, F1, F2, R3, act(GRC | ROUT | ZIN, 1), R5,
          F0, F1, F2, R3, act(GRC | ROUT | ZIN, 2), R5, IDLE_V};
    ir = 32'h1800_1234; start = 1'b1; mem_ready = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL b2b step %0d got %h want %h", i, obs, e[i]);
      end
      if (i == 6) ir = 32'h2000_5678;
      if (i == 11) start = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [25:0] e[$];
    e = '{F0, F1, F2, NOSTROBE, FAULT_V, FAULT_V, FAULT_V, FAULT_V};
    ir = 32'hF800_0000; start = 1'b1; mem_ready = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL illegal step %0d got %h want %h", i, obs, e[i]);
      end
      if (i >= 4) start = ~start;
    end
    start = 1'b0; clear = 1'b0; #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL illegal_clear got %h want %h", obs, IDLE_V);
    end
    clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL illegal_recover got %h want %h", obs, IDLE_V);
    end
  endtask

  task automatic test_mem_timeout();
    logic [25:0] e[$];
    e.push_back(F0);
    for (int unsigned k = 0; k < 16; k++) e.push_back(F1);
    e.push_back(FAULT_V);
    e.push_back(FAULT_V);
    ir = 32'h1800_0000; start = 1'b1; mem_ready = 1'b0;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL timeout step %0d got %h want %h", i, obs, e[i]);
      end
    end
    start = 1'b0; clear = 1'b0; #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL timeout_clear got %h want %h", obs, IDLE_V);
    end
    clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL timeout_recover got %h want %h", obs, IDLE_V);
    end
  endtask

  task automatic test_halt();
    logic [25:0] e[$];
    e = '{F0, F1, F2, NOSTROBE, IDLE_V, IDLE_V, IDLE_V, IDLE_V, IDLE_V};
    ir = 32'hD800_0000; start = 1'b1; mem_ready = 1'b1;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL halt step %0d got %h want %h", i, obs, e[i]);
      end
      if (i >= 4) start = ~start;
    end
    start = 1'b0; clear = 1'b0; #1;
    clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL halt_recover got %h want %h", obs, IDLE_V);
    end
  endtask

  task automatic test_clear_mid_wait();
    logic [25:0] e[$];
    bit m[$];
    e = '{F0, F1, F2, L3, L4, L5, act(READ | MDRIN, 0)};
    m = '{0, 1, 1, 1, 1, 1, 0};
    ir = 32'h0000_0000; start = 1'b1; mem_ready = 1'b0;
    foreach (e[i]) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== e[i]) begin
        errors++; $display("FAIL clr_wait step %0d got %h want %h", i, obs, e[i]);
      end
      mem_ready = m[i];
    end
    #2 clear = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL clr_async got %h want %h", obs, IDLE_V);
    end
    #1 clear = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++; $display("FAIL clr_idle got %h want %h", obs, IDLE_V);
    end
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; ir = '0; con_ff = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype(32'h1800_0000 | 32'h00A5_0000, 4'd1, "add");
    test_rtype(32'h2000_0000 | 32'h0011_2000, 4'd2, "sub");
    test_rtype(32'h2800_0000 | 32'h0022_4000, 4'd3, "and");
    test_rtype(32'h3000_0000 | 32'h0033_6000, 4'd4, "or");
    test_addi();
    test_ld_wait();
    test_st();
    test_br(1'b0);
    test_br(1'b1);
    test_nop();
    test_back_to_back();
    test_illegal();
    test_mem_timeout();
    test_halt();
    test_clear_mid_wait();
    checks++;
    if (excl_bad !== 0) begin
      errors++; $display("FAIL bus_exclusive violations %0d want 0", excl_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
